// File: rtl/leaf_collect_arb.sv
// leaf_collect_arb: five-source round-robin collector feeding a small
// output FIFO that carries {source index, payload} per entry.
// Optional per-source transfer counters on grant_cnt when
// LEAF_COLLECT_STATS_EN is defined.

`ifdef LEAF_COLLECT_STATS_EN
// Per-source 16-bit transfer counter, wraps 0xFFFF -> 0.
module leaf_collect_stat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);
    // Count completed transfers for one source
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= 16'd0;
        else if (inc) cnt <= cnt + 16'd1;
    end
endmodule
`endif

module leaf_collect_arb #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 in_valid,
    input  logic [5*DATA_W-1:0]        in_data,
    output logic [4:0]                 in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [2:0]                 out_src,
    input  logic                       out_ready,
`ifdef LEAF_COLLECT_STATS_EN
    output logic [5*16-1:0]            grant_cnt,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NSRC = 5;

    typedef struct packed {
        logic [2:0]        src;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [2:0]    last_grant;
    logic [2:0]    gnt_idx;
    logic          gnt_hit;
    logic [3:0]    scan;
    logic          full, pop, push, can_push;
    entry_t        wr_entry;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign can_push  = !full || pop;
    assign push      = |(in_valid & in_ready);

    // Round-robin search starting one past the last completed grant
    always_comb begin
        gnt_idx = 3'd0;
        gnt_hit = 1'b0;
        scan    = 4'd0;
        for (int k = 1; k <= NSRC; k++) begin
            scan = {1'b0, last_grant} + 4'(k);
            if (scan >= 4'd5) scan = scan - 4'd5;
            if (!gnt_hit && in_valid[scan[2:0]]) begin
                gnt_hit = 1'b1;
                gnt_idx = scan[2:0];
            end
        end
    end

    // Winner-only ready, blocked while in reset or when no room this cycle
    always_comb begin
        in_ready = 5'b0;
        if (!rst && gnt_hit && can_push) in_ready = 5'b1 << gnt_idx;
    end

    // Build the tail entry from the winner's slice only
    always_comb begin
        wr_entry.src  = gnt_idx;
        wr_entry.data = in_data[gnt_idx*DATA_W +: DATA_W];
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        out_data = '0;
        out_src  = 3'd0;
        if (out_valid) begin
            out_data = mem[rptr].data;
            out_src  = mem[rptr].src;
        end
    end

    // FIFO storage; contents are don't-care once pointers are cleared
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_entry;
    end

    // Pointers, occupancy and arbitration history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            last_grant <= 3'd4;
        end else begin
            if (push) begin
                wptr       <= wptr + AW'(1);
                last_grant <= gnt_idx;
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LEAF_COLLECT_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_stat
            leaf_collect_stat_cnt u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (in_valid[gi] && in_ready[gi]),
                .cnt (grant_cnt[gi*16 +: 16])
            );
        end
    endgenerate
`endif

endmodule

// File: tb/tb_leaf_collect_arb.sv
// Directed bench for leaf_collect_arb: vector table plus a few
// hand-written multi-cycle sequences.
module tb_leaf_collect_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_valid = 5'b0;
    logic [39:0] in_data = 40'h0;
    logic [4:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_src;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
`ifdef LEAF_COLLECT_STATS_EN
    logic [79:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leaf_collect_arb #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
`ifdef LEAF_COLLECT_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .count     (count)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  iv;
        logic [39:0] id;
        logic        ordy;
        logic [4:0]  e_ir;
        logic        e_ov;
        logic [2:0]  e_src;
        logic [7:0]  e_dat;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam logic [39:0] D  = 40'h14_13_12_11_10;
    localparam logic [39:0] DA = 40'h77_A5_66_55_44;

    vec_t tbl [32];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic set(input int i, input logic r, input logic [4:0] iv, input logic [39:0] id,
                       input logic o, input logic [4:0] ir, input logic ov, input logic [2:0] s,
                       input logic [7:0] d, input logic [2:0] c);
        tbl[i] = '{r, iv, id, o, ir, ov, s, d, c};
    endtask

    initial begin
        // reset state / round-robin with all requesting
        set( 0, 1, 5'h1F, D, 0, 5'h00, 0, 0, 8'h00, 0);
        set( 1, 0, 5'h1F, D, 1, 5'h01, 0, 0, 8'h00, 0);
        set( 2, 0, 5'h1F, D, 1, 5'h02, 1, 0, 8'h10, 1);
        set( 3, 0, 5'h1F, D, 1, 5'h04, 1, 1, 8'h11, 1);
        set( 4, 0, 5'h1F, D, 1, 5'h08, 1, 2, 8'h12, 1);
        set( 5, 0, 5'h1F, D, 1, 5'h10, 1, 3, 8'h13, 1);
        set( 6, 0, 5'h1F, D, 1, 5'h01, 1, 4, 8'h14, 1);
        set( 7, 0, 5'h00, D, 1, 5'h00, 1, 0, 8'h10, 1);
        set( 8, 0, 5'h00, D, 0, 5'h00, 0, 0, 8'h00, 0);
        // fill to full with out_ready low
        set( 9, 1, 5'h1F, D, 0, 5'h00, 0, 0, 8'h00, 0);
        set(10, 0, 5'h1F, D, 0, 5'h01, 0, 0, 8'h00, 0);
        set(11, 0, 5'h1F, D, 0, 5'h02, 1, 0, 8'h10, 1);
        set(12, 0, 5'h1F, D, 0, 5'h04, 1, 0, 8'h10, 2);
        set(13, 0, 5'h1F, D, 0, 5'h08, 1, 0, 8'h10, 3);
        set(14, 0, 5'h1F, D, 0, 5'h00, 1, 0, 8'h10, 4);
        set(15, 0, 5'h1F, D, 0, 5'h00, 1, 0, 8'h10, 4);
        // push+pop while full, then drain in order
        set(16, 0, 5'h04, D, 1, 5'h04, 1, 0, 8'h10, 4);
        set(17, 0, 5'h00, D, 1, 5'h00, 1, 1, 8'h11, 4);
        set(18, 0, 5'h00, D, 1, 5'h00, 1, 2, 8'h12, 3);
        set(19, 0, 5'h00, D, 1, 5'h00, 1, 3, 8'h13, 2);
        set(20, 0, 5'h00, D, 1, 5'h00, 1, 2, 8'h12, 1);
        set(21, 0, 5'h00, D, 0, 5'h00, 0, 0, 8'h00, 0);
        // lone source 3 with 0xA5, others carry junk
        set(22, 0, 5'h08, DA, 1, 5'h08, 0, 0, 8'h00, 0);
        set(23, 0, 5'h00, D, 1, 5'h00, 1, 3, 8'hA5, 1);
        set(24, 0, 5'h00, D, 0, 5'h00, 0, 0, 8'h00, 0);
        // reset with three entries queued
        set(25, 0, 5'h1F, D, 0, 5'h10, 0, 0, 8'h00, 0);
        set(26, 0, 5'h1F, D, 0, 5'h01, 1, 4, 8'h14, 1);
        set(27, 0, 5'h1F, D, 0, 5'h02, 1, 4, 8'h14, 2);
        set(28, 1, 5'h1F, D, 0, 5'h00, 0, 0, 8'h00, 0);
        set(29, 0, 5'h1F, D, 0, 5'h01, 0, 0, 8'h00, 0);
        set(30, 0, 5'h00, D, 1, 5'h00, 1, 0, 8'h10, 1);
        set(31, 0, 5'h00, D, 0, 5'h00, 0, 0, 8'h00, 0);

        #1;
        chk("rst_count", -1, 32'(count), 0);
        chk("rst_out_valid", -1, 32'(out_valid), 0);
        chk("rst_in_ready", -1, 32'(in_ready), 0);

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            #1;
            chk("in_ready",  i, 32'(in_ready),  32'(tbl[i].e_ir));
            chk("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
            chk("out_src",   i, 32'(out_src),   32'(tbl[i].e_src));
            chk("out_data",  i, 32'(out_data),  32'(tbl[i].e_dat));
            chk("count",     i, 32'(count),     32'(tbl[i].e_cnt));
            @(negedge clk);
        end

        // valid pulse that drops before the edge: no transfer, grant history held
        in_valid = 5'h04; #2 in_valid = 5'h00;
        @(negedge clk);
        chk("drop_count", 0, 32'(count), 0);
        in_valid = 5'h1F; #1;
        chk("drop_next_grant", 0, 32'(in_ready), 32'h02);

        // reset asserted between edges clears state immediately
        @(posedge clk); #2;
        in_valid = 5'h00;
        chk("mid_pre_count", 0, 32'(count), 1);
        rst = 1'b1; #1;
        chk("mid_count", 0, 32'(count), 0);
        chk("mid_out_valid", 0, 32'(out_valid), 0);
        chk("mid_out_src", 0, 32'(out_src), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 5'h1F; #1;
        chk("mid_next_grant", 0, 32'(in_ready), 32'h01);
        in_valid = 5'h00;

`ifdef LEAF_COLLECT_STATS_EN
        @(negedge clk);
        rst = 1'b1; #1;
        chk("stat_rst", 0, 32'(grant_cnt[31:0]), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 5'h02; out_ready = 1'b1;
        repeat (65537) @(negedge clk);
        in_valid = 5'h00; #1;
        for (int s = 0; s < 5; s++)
            chk("grant_cnt", s, 32'(grant_cnt[s*16 +: 16]), (s == 1) ? 32'd1 : 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/leaf_collect_arb.md
LEAF_COLLECT_ARB -- requirements
Module: leaf_collect_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per source.
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  5  per-source valid, one bit per child instance 0..4.
REQ-006 SHALL have port in_data  input  5*DATA_W  packed payloads; source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_ready  output  5  per-source accept; at most one bit high per cycle.
REQ-008 SHALL have port out_valid  output  1  FIFO head valid.
REQ-009 SHALL have port out_data  output  DATA_W  FIFO head payload.
REQ-010 SHALL have port out_src  output  3  FIFO head source index, 0..4.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL perform a transfer on source i when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-014 SHALL grant round-robin: search starts at (last_grant+1) mod 5; first requesting source wins.
REQ-015 SHALL assert in_ready[g] combinationally only for the winner g, and only when the FIFO is not full or a pop occurs in the same cycle.
REQ-016 SHALL update last_grant only on a completed input transfer; if there is no transfer, last_grant holds.
REQ-017 SHALL write {source index, payload} into the FIFO tail on a transfer; one-cycle latency from input transfer to out_valid when the FIFO was empty.
REQ-018 SHALL pop the head when out_valid and out_ready are both high.
REQ-019 SHALL, on a simultaneous push and pop, keep count unchanged and preserve order; this is allowed when the FIFO is full.
REQ-020 SHALL hold out_data and out_src stable while out_valid is high and out_ready is low.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-022 SHALL ignore in_data bits of non-granted sources; in_valid may drop without a transfer and no state changes.
REQ-023 SHALL drive out_data and out_src to 0 when the FIFO is empty.

Reset
REQ-024 SHALL, on rst high, asynchronously clear the pointers and count, set last_grant=4 (so source 0 has first priority), and drive out_valid=0, in_ready=0, out_data=0, out_src=0.
REQ-025 SHALL discard FIFO contents when reset is asserted mid-operation; no partial transfer completes in a cycle where rst is high.
REQ-026 SHALL resume arbitration on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro LEAF_COLLECT_STATS_EN is defined, add output grant_cnt (5*16 bits): a per-source 16-bit counter incremented on each transfer, wrapping 0xFFFF->0, and cleared by rst.
REQ-028 SHALL, without LEAF_COLLECT_STATS_EN, omit the grant_cnt port and its counters entirely; all other behaviour is identical.

Verification
REQ-029 Bench SHALL cover: reset, then in_valid=5'b11111 with out_ready=1 -> grant order 0,1,2,3,4,0; out_src follows the same sequence one cycle later.
REQ-030 Bench SHALL cover: out_ready=0, all sources valid -> after 4 transfers count=4 and in_ready=0; head holds out_src=0 and stable data.
REQ-031 Bench SHALL cover: FIFO full, out_ready=1, in_valid[2]=1 -> push and pop in the same cycle, count stays 4, order preserved.
REQ-032 Bench SHALL cover: only in_valid[3] requesting, data 0xA5 -> in_ready=5'b01000, next cycle out_valid=1, out_data=0xA5, out_src=3.
REQ-033 Bench SHALL cover: rst pulsed with count=3 -> count=0, out_valid=0 immediately, next grant goes to source 0.
REQ-034 Bench SHALL cover, with LEAF_COLLECT_STATS_EN: 65537 transfers from source 1 -> grant_cnt[1]=1, other counters 0.
